// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply array.
//   state_t      : controller states (IDLE, COMPUTE, FLUSH, DRAIN)
//   DEF_DATA_W   : default operand width
//   DEF_ACC_W    : default accumulator width
//   sext_or_zext : widens a value to EXT_W bits, either sign- or zero-extended
package systolic_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int EXT_W      = 64;   // widest operand/product/accumulator supported

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FLUSH   = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Treat the low from_w bits of val as the real value and fill everything
    // above with either its sign bit or zeros. from_w is always a constant at
    // the call sites, so this folds down to plain wiring.
    function automatic logic [EXT_W-1:0] sext_or_zext(input logic [EXT_W-1:0] val,
                                                      input int              from_w,
                                                      input logic            is_signed);
        logic [EXT_W-1:0] r;
        r = val;
        for (int b = 0; b < EXT_W; b++) begin
            if (b >= from_w) r[b] = is_signed & val[from_w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the output-stationary array.
//   a_in/a_valid_in  : operand from the west, passed east one cycle later
//   b_in/b_valid_in  : operand from the north, passed south one cycle later
//   clear            : synchronous zero of the accumulator (wins over a MAC)
//   signed_mode      : 1 = two's-complement operands, 0 = unsigned
//   acc              : accumulator, read in parallel by the drain mux
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid_out,
    output logic [ACC_W-1:0]  acc
);

    logic [2*DATA_W-1:0] a_wide, b_wide, prod;
    logic [ACC_W-1:0]    prod_acc;

    // A 2*DATA_W-bit multiply of extended operands gives the exact product
    // for both signed and unsigned inputs; it is then widened to ACC_W.
    assign a_wide   = (2*DATA_W)'(sext_or_zext(EXT_W'(a_in), DATA_W, signed_mode));
    assign b_wide   = (2*DATA_W)'(sext_or_zext(EXT_W'(b_in), DATA_W, signed_mode));
    assign prod     = a_wide * b_wide;
    assign prod_acc = ACC_W'(sext_or_zext(EXT_W'(prod), 2*DATA_W, signed_mode));

    // NOTE: registers are updated with <= so every PE samples its neighbours'
    // values from before the edge; blocking assignments would let data race
    // through several PEs in a single cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out       <= '0;
            a_valid_out <= 1'b0;
            b_out       <= '0;
            b_valid_out <= 1'b0;
            acc         <= '0;
        end else begin
            a_out       <= a_in;
            a_valid_out <= a_valid_in;
            b_out       <= b_in;
            b_valid_out <= b_valid_in;
            if (clear)
                acc <= '0;
            else if (a_valid_in && b_valid_in)
                acc <= acc + prod_acc;   // wraps modulo 2^ACC_W
        end
    end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Output-stationary ROWS x COLS systolic matrix multiplier with its controller.
//   start/k_len/acc_mode/signed_mode : job launch, sampled in IDLE only
//   in_valid/in_ready/a_in/b_in      : one K-beat per accepted handshake
//   out_valid/out_ready/out_row/out_data : row-by-row drain of C
//   busy : not IDLE;  done : one-cycle pulse after the last row handshake
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS   = 32,
    parameter int COLS   = 32,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int K_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [K_W-1:0]           k_len,
    input  logic                     acc_mode,
    input  logic                     signed_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DATA_W-1:0]   a_in,
    input  logic [COLS*DATA_W-1:0]   b_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(ROWS)-1:0]  out_row,
    output logic [COLS*ACC_W-1:0]    out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int ROW_W     = $clog2(ROWS);
    // The last accepted beat reaches PE(ROWS-1,COLS-1) ROWS+COLS-2 cycles later.
    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FLUSH_W   = $clog2(FLUSH_LEN + 1);

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, beat_cnt;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [ROW_W-1:0]   row_q;
    logic               signed_q, done_q;
    logic               accept, last_beat, flush_end, last_row, clear_acc;

    // Grid wiring: a moves east (column index 0..COLS), b moves south.
    logic [DATA_W-1:0] a_h   [ROWS][COLS+1];
    logic              av_h  [ROWS][COLS+1];
    logic [DATA_W-1:0] b_v   [ROWS+1][COLS];
    logic              bv_v  [ROWS+1][COLS];
    logic [ACC_W-1:0]  acc_grid [ROWS][COLS];

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == COMPUTE);
    assign out_valid = (state_q == DRAIN);
    assign out_row   = row_q;
    assign done      = done_q;

    assign accept    = in_valid && (state_q == COMPUTE);
    assign last_beat = accept && (beat_cnt == k_q - K_W'(1));
    assign flush_end = (flush_cnt == FLUSH_W'(FLUSH_LEN - 1));
    assign last_row  = (row_q == ROW_W'(ROWS - 1));

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clear_acc = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                clear_acc = !acc_mode;
                state_d   = (k_len != '0) ? COMPUTE : DRAIN;
            end
            COMPUTE: if (last_beat)              state_d = FLUSH;
            FLUSH:   if (flush_end)              state_d = DRAIN;
            DRAIN:   if (out_ready && last_row)  state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            signed_q  <= 1'b0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DRAIN) && out_ready && last_row;
            case (state_q)
                IDLE: begin
                    beat_cnt  <= '0;
                    flush_cnt <= '0;
                    row_q     <= '0;
                    if (start) begin
                        k_q      <= k_len;
                        signed_q <= signed_mode;
                    end
                end
                COMPUTE: if (accept)    beat_cnt  <= beat_cnt + K_W'(1);
                FLUSH:                  flush_cnt <= flush_cnt + FLUSH_W'(1);
                DRAIN:   if (out_ready) row_q     <= row_q + ROW_W'(1);
                default: ;
            endcase
        end
    end

    // Input skew: row i of A is delayed i cycles, column j of B j cycles,
    // each stage carrying a valid bit so bubbles travel as empty slots.
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign a_h[0][0]  = a_in[0 +: DATA_W];
            assign av_h[0][0] = accept;
        end else begin : g_delay
            logic [DATA_W-1:0] sr_d [i];
            logic              sr_v [i];
            // NOTE: the skew stages are reset even though they are arrays; a
            // stale valid bit left in flight would add into the next job.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) begin
                        sr_d[k] <= '0;
                        sr_v[k] <= 1'b0;
                    end
                end else begin
                    sr_d[0] <= a_in[i*DATA_W +: DATA_W];
                    sr_v[0] <= accept;
                    for (int k = 1; k < i; k++) begin
                        sr_d[k] <= sr_d[k-1];
                        sr_v[k] <= sr_v[k-1];
                    end
                end
            end
            assign a_h[i][0]  = sr_d[i-1];
            assign av_h[i][0] = sr_v[i-1];
        end
        logic unused_east;
        assign unused_east = ^{a_h[i][COLS], av_h[i][COLS]};
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign b_v[0][0]  = b_in[0 +: DATA_W];
            assign bv_v[0][0] = accept;
        end else begin : g_delay
            logic [DATA_W-1:0] sr_d [j];
            logic              sr_v [j];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < j; k++) begin
                        sr_d[k] <= '0;
                        sr_v[k] <= 1'b0;
                    end
                end else begin
                    sr_d[0] <= b_in[j*DATA_W +: DATA_W];
                    sr_v[0] <= accept;
                    for (int k = 1; k < j; k++) begin
                        sr_d[k] <= sr_d[k-1];
                        sr_v[k] <= sr_v[k-1];
                    end
                end
            end
            assign b_v[0][j]  = sr_d[j-1];
            assign bv_v[0][j] = sr_v[j-1];
        end
        logic unused_south;
        assign unused_south = ^{b_v[ROWS][j], bv_v[ROWS][j]};
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk         (clk),
                .rst         (rst),
                .clear       (clear_acc),
                .signed_mode (signed_q),
                .a_in        (a_h[i][j]),
                .a_valid_in  (av_h[i][j]),
                .b_in        (b_v[i][j]),
                .b_valid_in  (bv_v[i][j]),
                .a_out       (a_h[i][j+1]),
                .a_valid_out (av_h[i][j+1]),
                .b_out       (b_v[i+1][j]),
                .b_valid_out (bv_v[i+1][j]),
                .acc         (acc_grid[i][j])
            );
        end
    end

    // Drain mux: present the selected accumulator row only while draining.
    always_comb begin
        out_data = '0;
        if (state_q == DRAIN) begin
            for (int j = 0; j < COLS; j++) out_data[j*ACC_W +: ACC_W] = acc_grid[row_q][j];
        end
    end

endmodule
